// File: rtl/synapse_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : synapse_accumulator
// Purpose  : Sums the stored weights of the spiking inputs and saturates the
//            result. The sum is presented with a valid/ready handshake.
//            The optional sparse scan is enabled by SYNAPSE_SPARSE_SCAN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module synapse_accumulator #(
    parameter int N_INPUTS = 8,
    parameter int W_WIDTH  = 8,
    parameter int AW       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INPUTS-1:0] spike_in,
    input  logic                spike_valid,
    output logic                spike_ready,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [W_WIDTH-1:0]  wr_data,
    output logic [W_WIDTH-1:0]  weight_sum,
    output logic                sum_valid,
    input  logic                sum_ready
);

    localparam logic [1:0]         c_IDLE    = 2'd0;
    localparam logic [1:0]         c_ACCUM   = 2'd1;
    localparam logic [1:0]         c_DONE    = 2'd2;
    localparam logic [W_WIDTH-1:0] c_SAT_MAX = '1;

    logic [1:0]          r_state;
    logic [N_INPUTS-1:0] r_vec;
    logic [W_WIDTH-1:0]  r_acc;
    logic [W_WIDTH-1:0]  r_weight_sum;
    logic                r_sum_valid;
    logic [W_WIDTH-1:0]  r_weights [N_INPUTS];

    logic [AW-1:0]       w_idx;
    logic                w_hit;
    logic                w_last;
    logic [N_INPUTS-1:0] w_vec_next;
    logic [W_WIDTH:0]    w_add;
    logic [W_WIDTH-1:0]  w_acc_next;

    assign spike_ready = (r_state == c_IDLE) && !rst;
    assign weight_sum  = r_weight_sum;
    assign sum_valid   = r_sum_valid;

`ifdef SYNAPSE_SPARSE_SCAN_EN
    // Visit only set bits: lowest set index, then clear it from the vector.
    always_comb begin
        w_idx = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            if (r_vec[i]) w_idx = AW'(i);
        end
    end

    assign w_hit      = |r_vec;
    assign w_vec_next = r_vec & (r_vec - N_INPUTS'(1));
    assign w_last     = (w_vec_next == '0);
`else
    logic [AW-1:0] r_idx;

    assign w_idx      = r_idx;
    assign w_hit      = r_vec[r_idx];
    assign w_vec_next = r_vec;
    assign w_last     = (r_idx == AW'(N_INPUTS - 1));

    always_ff @(posedge clk) begin
        if (rst || r_state != c_ACCUM) begin
            r_idx <= '0;
        end else begin
            r_idx <= r_idx + AW'(1);
        end
    end
`endif

    // One extra carry bit detects overflow so the sum clamps instead of wrapping.
    assign w_add      = {1'b0, r_acc} + {1'b0, r_weights[w_idx]};
    assign w_acc_next = w_add[W_WIDTH] ? c_SAT_MAX : w_add[W_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_vec        <= '0;
            r_acc        <= '0;
            r_weight_sum <= '0;
            r_sum_valid  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (spike_valid) begin
                        r_vec   <= spike_in;
                        r_acc   <= '0;
                        r_state <= c_ACCUM;
                    end
                end
                c_ACCUM: begin
                    if (w_hit) r_acc <= w_acc_next;
                    r_vec <= w_vec_next;
                    if (w_last) begin
                        r_weight_sum <= w_hit ? w_acc_next : r_acc;
                        r_sum_valid  <= 1'b1;
                        r_state      <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (sum_ready) begin
                        r_sum_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Reads in the same cycle see the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) r_weights[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < N_INPUTS)) begin
            r_weights[wr_addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_synapse_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_synapse_accumulator
// Purpose  : Self-checking bench for synapse_accumulator, scoreboard based.
// Revision : 1.0 - initial release
// ============================================================================
module tb_synapse_accumulator;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int AW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] spike_in = '0;
    logic         spike_valid = 1'b0;
    logic         spike_ready;
    logic         wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] weight_sum;
    logic         sum_valid;
    logic         sum_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int model_w [N];
    int exp_q [$];
    int lat_q [$];

    synapse_accumulator #(.N_INPUTS(N), .W_WIDTH(W), .AW(AW)) dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .spike_valid(spike_valid),
        .spike_ready(spike_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .weight_sum(weight_sum), .sum_valid(sum_valid),
        .sum_ready(sum_ready)
    );

    always #5 clk = ~clk;

    function automatic int model_sum(input logic [N-1:0] v);
        int s = 0;
        for (int i = 0; i < N; i++) if (v[i]) s += model_w[i];
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int exp_lat(input logic [N-1:0] v);
`ifdef SYNAPSE_SPARSE_SCAN_EN
        return ($countones(v) > 0) ? $countones(v) : 1;
`else
        return N;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_w(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = W'(d);
        tick();
        wr_en = 1'b0;
        model_w[a] = d;
    endtask

    task automatic accept(input logic [N-1:0] v, input int e);
        int n = 0;
        spike_in    = v;
        spike_valid = 1'b1;
        while (!spike_ready && n < 50) begin
            tick();
            n++;
        end
        if (!spike_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: spike_ready=%0b required 1", spike_ready);
            spike_valid = 1'b0;
            return;
        end
        tick();
        cyc = 0;
        spike_valid = 1'b0;
        exp_q.push_back(e);
        lat_q.push_back(exp_lat(v));
    endtask

    task automatic wait_sum(input string name);
        int e, l;
        while (!sum_valid && cyc < 100) tick();
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        total++;
        if (!sum_valid) begin
            bad++;
            $display("FAIL %s_timeout: sum_valid=%0b required 1", name, sum_valid);
            return;
        end
        if (cyc !== l) begin
            bad++;
            $display("FAIL %s_latency: got %0d required %0d", name, cyc, l);
        end
        total++;
        if (weight_sum !== W'(e)) begin
            bad++;
            $display("FAIL %s_sum: got %0d required %0d", name, weight_sum, e);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (spike_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_low: got %0b required 0", spike_ready);
        end
        total++;
        if (sum_valid !== 1'b0 || weight_sum !== '0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%0b sum=%0d required 0/0", sum_valid, weight_sum);
        end
        rst = 1'b0;
        #1;
        total++;
        if (spike_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_high: got %0b required 1", spike_ready);
        end
        accept(8'hFF, model_sum(8'hFF));
        wait_sum("reset_weights_zero");
    endtask

    task automatic test_basic;
        tick();
        for (int i = 0; i < N; i++) write_w(i, i + 1);
        accept(8'h05, model_sum(8'h05));
        wait_sum("basic_05");
        tick();
        total++;
        if (sum_valid !== 1'b0 || spike_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake_idle: valid=%0b ready=%0b required 0/1", sum_valid, spike_ready);
        end
        accept(8'hFF, model_sum(8'hFF));
        wait_sum("basic_ff");
        accept(8'hA0, model_sum(8'hA0));
        wait_sum("back_to_back_a0");
    endtask

    task automatic test_saturation;
        tick();
        for (int i = 0; i < N; i++) write_w(i, 200);
        accept(8'h03, model_sum(8'h03));
        wait_sum("sat_03");
        accept(8'h00, model_sum(8'h00));
        wait_sum("zero_vector");
        accept(8'hFF, model_sum(8'hFF));
        wait_sum("sat_ff");
    endtask

    task automatic test_backpressure;
        tick();
        sum_ready = 1'b0;
        accept(8'h01, model_sum(8'h01));
        wait_sum("bp_sum");
        spike_in    = 8'hFF;
        spike_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (sum_valid !== 1'b1 || weight_sum !== 8'd200 || spike_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: valid=%0b sum=%0d ready=%0b required 1/200/0",
                         sum_valid, weight_sum, spike_ready);
            end
        end
        spike_valid = 1'b0;
        sum_ready   = 1'b1;
        tick();
        total++;
        if (sum_valid !== 1'b0 || spike_ready !== 1'b1 || weight_sum !== 8'd200) begin
            bad++;
            $display("FAIL bp_release: valid=%0b ready=%0b sum=%0d required 0/1/200",
                     sum_valid, spike_ready, weight_sum);
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        tick();
        accept(8'hFF, model_sum(8'hFF));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        for (int i = 0; i < N; i++) model_w[i] = 0;
        total++;
        if (spike_ready !== 1'b1) begin
            bad++; $display("FAIL mid_rst_ready: got %0b required 1", spike_ready);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sum_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL mid_rst_no_valid: seen=%0b required 0", seen);
        end
        accept(8'hFF, model_sum(8'hFF));
        wait_sum("mid_rst_weights_cleared");
    endtask

    task automatic test_rbw;
`ifdef SYNAPSE_SPARSE_SCAN_EN
        int e2 = 1;
`else
        int e2 = 3;
`endif
        tick();
        write_w(2, 10);
        accept(8'h04, 10);
        for (int k = 1; k < e2; k++) tick();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'd50;
        tick();
        wr_en = 1'b0;
        model_w[2] = 50;
        wait_sum("rbw_old_value");
        tick();
        write_w(2, 10);
        accept(8'h44, 60);
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'd50;
        tick();
        wr_en = 1'b0;
        model_w[6] = 50;
        wait_sum("write_ahead");
    endtask

    task automatic test_latency_corners;
        tick();
        accept(8'h80, model_sum(8'h80));
        wait_sum("lat_80");
        accept(8'h81, model_sum(8'h81));
        wait_sum("lat_81");
        accept(8'h00, model_sum(8'h00));
        wait_sum("lat_00");
    endtask

    task automatic test_random;
        logic [N-1:0] v;
        tick();
        for (int r = 0; r < 1000; r++) begin
            if (r % 100 == 0) begin
                for (int i = 0; i < N; i++)
                    write_w(i, int'($urandom_range(0, (r % 200 == 0) ? 255 : 60)));
            end
            v = N'($urandom);
            accept(v, model_sum(v));
            wait_sum("random");
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) model_w[i] = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_rbw();
        test_latency_corners();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
